// File: rtl/csr_uartfifo_tx.sv
// UARTFIFO CSR transmit consumer: buffers CSR-written bytes in a circular FIFO
// and serialises them 8N1, LSB first, on a registered idle-high TX line.
module csr_uartfifo_tx #(
    parameter int DEPTH   = 16,
    parameter int CLK_DIV = 434
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        csr_we,
    input  logic [31:0] csr_wdata,
    output logic [31:0] csr_rdata,
    output logic        uart_tx,
    output logic        fifo_full,
    output logic        fifo_empty
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH) + 1;
    localparam int BW = $clog2(CLK_DIV);
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);
    localparam logic [BW-1:0] BAUD_LOAD  = BW'(CLK_DIV - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP
    } state_e;

    logic [7:0]    mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          ovf_q, ovf_d;

    state_e        state_q;
    logic [BW-1:0] baud_q;
    logic [2:0]    bit_q;
    logic [7:0]    shift_q;
    logic          tx_q;

    logic full, empty, busy;
    logic clr_cmd, wr_req, push, pop;
    logic unused_wdata;

    assign full    = (count_q == FULL_COUNT);
    assign empty   = (count_q == '0);
    assign busy    = (state_q != ST_IDLE);

    // Full is judged on the registered count, so a same-cycle pop never frees a slot.
    assign clr_cmd = csr_we && csr_wdata[31];
    assign wr_req  = csr_we && !csr_wdata[31];
    assign push    = wr_req && !full;
    assign pop     = (state_q == ST_IDLE) && !empty;

    assign unused_wdata = ^csr_wdata[30:8];

    // NOTE: every variable gets a default at the top of always_comb so no latch is inferred.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        ovf_d    = ovf_q;

        if (push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;

        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase

        if (clr_cmd) begin
            ovf_d = 1'b0;
        end else if (wr_req && full) begin
            ovf_d = 1'b1;
        end
    end

    // NOTE: the storage array is deliberately not reset; count and pointers define validity.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= csr_wdata[7:0];
        end
    end

    // NOTE: sequential state is updated with non-blocking assignments only.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
        end
    end

    // The TX level is registered alongside each transition so it changes with the state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            tx_q    <= 1'b1;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    tx_q <= 1'b1;
                    if (pop) begin
                        shift_q <= mem_q[rd_ptr_q];
                        baud_q  <= BAUD_LOAD;
                        tx_q    <= 1'b0;
                        state_q <= ST_START;
                    end
                end
                ST_START: begin
                    if (baud_q == '0) begin
                        baud_q  <= BAUD_LOAD;
                        bit_q   <= '0;
                        tx_q    <= shift_q[0];
                        state_q <= ST_DATA;
                    end else begin
                        baud_q <= baud_q - 1'b1;
                    end
                end
                ST_DATA: begin
                    if (baud_q == '0) begin
                        baud_q <= BAUD_LOAD;
                        if (bit_q == 3'd7) begin
                            tx_q    <= 1'b1;
                            state_q <= ST_STOP;
                        end else begin
                            bit_q <= bit_q + 3'd1;
                            tx_q  <= shift_q[bit_q + 3'd1];
                        end
                    end else begin
                        baud_q <= baud_q - 1'b1;
                    end
                end
                ST_STOP: begin
                    if (baud_q == '0) begin
                        state_q <= ST_IDLE;
                    end else begin
                        baud_q <= baud_q - 1'b1;
                    end
                end
                default: begin
                    tx_q    <= 1'b1;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign uart_tx    = tx_q;
    assign fifo_full  = full;
    assign fifo_empty = empty;
    assign csr_rdata  = {16'h0000, 8'(count_q), 4'h0, ovf_q, busy, empty, full};

endmodule

// File: tb/tb_csr_uartfifo_tx.sv
// Directed bench for csr_uartfifo_tx with DEPTH=4, CLK_DIV=4: inputs driven and
// outputs sampled on the falling edge, expected frames built from the 8N1 format.
module tb_csr_uartfifo_tx;

    localparam int DEPTH   = 4;
    localparam int CLK_DIV = 4;
    localparam int FRAME   = 10 * CLK_DIV;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        csr_we = 1'b0;
    logic [31:0] csr_wdata = '0;
    logic [31:0] csr_rdata;
    logic        uart_tx;
    logic        fifo_full;
    logic        fifo_empty;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    csr_uartfifo_tx #(
        .DEPTH   (DEPTH),
        .CLK_DIV (CLK_DIV)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .csr_we     (csr_we),
        .csr_wdata  (csr_wdata),
        .csr_rdata  (csr_rdata),
        .uart_tx    (uart_tx),
        .fifo_full  (fifo_full),
        .fifo_empty (fifo_empty)
    );

    // Per-cycle TX level of one frame: start bit, eight data bits LSB first, stop bit.
    function automatic logic [FRAME-1:0] frame_of(input logic [7:0] b);
        logic [FRAME-1:0] f;
        int slot;
        for (int i = 0; i < FRAME; i++) begin
            slot = i / CLK_DIV;
            if (slot == 0)      f[i] = 1'b0;
            else if (slot == 9) f[i] = 1'b1;
            else                f[i] = b[slot-1];
        end
        return f;
    endfunction

    task automatic capture(input int first, output logic [FRAME-1:0] tx_s,
                           output logic [FRAME-1:0] busy_s);
        tx_s   = '0;
        busy_s = '0;
        for (int i = first; i < FRAME; i++) begin
            tx_s[i]   = uart_tx;
            busy_s[i] = csr_rdata[2];
            @(negedge clk);
        end
    endtask

    task automatic write_word(input logic [31:0] d);
        csr_we    = 1'b1;
        csr_wdata = d;
        @(negedge clk);
        csr_we    = 1'b0;
        csr_wdata = '0;
    endtask

    task automatic test_reset();
        int bad;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (csr_rdata !== 32'h2 || uart_tx !== 1'b1) begin
            errors++;
            $display("FAIL reset_during status=%h tx=%b want status=00000002 tx=1", csr_rdata, uart_tx);
        end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (csr_rdata !== 32'h2) begin
            errors++;
            $display("FAIL reset_status got %h want 00000002", csr_rdata);
        end
        checks++;
        if (fifo_full !== 1'b0 || fifo_empty !== 1'b1) begin
            errors++;
            $display("FAIL reset_flags full=%b empty=%b want full=0 empty=1", fifo_full, fifo_empty);
        end
        bad = 0;
        repeat (100) begin
            if (uart_tx !== 1'b1) bad++;
            @(negedge clk);
        end
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL reset_idle_tx low_cycles=%0d want 0", bad);
        end
    endtask

    task automatic test_single_frame();
        logic [FRAME-1:0] ts, bs;
        write_word(32'h0000_0055);
        checks++;
        if (uart_tx !== 1'b1 || csr_rdata !== 32'h0000_0100) begin
            errors++;
            $display("FAIL single_accept tx=%b status=%h want tx=1 status=00000100", uart_tx, csr_rdata);
        end
        @(negedge clk);
        checks++;
        if (uart_tx !== 1'b0 || csr_rdata !== 32'h0000_0006) begin
            errors++;
            $display("FAIL single_latency tx=%b status=%h want tx=0 status=00000006", uart_tx, csr_rdata);
        end
        capture(0, ts, bs);
        checks++;
        if (ts !== frame_of(8'h55)) begin
            errors++;
            $display("FAIL single_frame got %h want %h", ts, frame_of(8'h55));
        end
        checks++;
        if (bs !== {FRAME{1'b1}}) begin
            errors++;
            $display("FAIL single_busy got %h want %h", bs, {FRAME{1'b1}});
        end
        checks++;
        if (uart_tx !== 1'b1 || csr_rdata !== 32'h2) begin
            errors++;
            $display("FAIL single_after tx=%b status=%h want tx=1 status=00000002", uart_tx, csr_rdata);
        end
    endtask

    task automatic test_overflow_stream();
        logic [FRAME-1:0] ts, bs, mask;
        logic [31:0] exp;
        int bad;
        csr_we = 1'b1;
        for (int d = 1; d <= 6; d++) begin
            csr_wdata = 32'(d);
            @(negedge clk);
        end
        csr_we    = 1'b0;
        csr_wdata = '0;
        checks++;
        if (csr_rdata !== 32'h0000_040D || fifo_full !== 1'b1) begin
            errors++;
            $display("FAIL stream_status got %h full=%b want 0000040d full=1", csr_rdata, fifo_full);
        end
        // The first frame started four cycles ago.
        mask = {FRAME{1'b1}} << 4;
        capture(4, ts, bs);
        checks++;
        if ((ts & mask) !== (frame_of(8'h01) & mask) || (bs & mask) !== mask) begin
            errors++;
            $display("FAIL stream_frame1 tx=%h busy=%h want tx=%h busy=%h",
                     ts & mask, bs & mask, frame_of(8'h01) & mask, mask);
        end
        for (int k = 2; k <= 5; k++) begin
            exp = {16'h0, 8'(6 - k), 4'h0, 1'b1, 1'b0, 1'b0, (k == 2)};
            checks++;
            if (uart_tx !== 1'b1 || csr_rdata !== exp) begin
                errors++;
                $display("FAIL stream_gap%0d tx=%b status=%h want tx=1 status=%h", k, uart_tx, csr_rdata, exp);
            end
            @(negedge clk);
            capture(0, ts, bs);
            checks++;
            if (ts !== frame_of(8'(k)) || bs !== {FRAME{1'b1}}) begin
                errors++;
                $display("FAIL stream_frame%0d tx=%h busy=%h want tx=%h busy=%h",
                         k, ts, bs, frame_of(8'(k)), {FRAME{1'b1}});
            end
        end
        checks++;
        if (csr_rdata !== 32'h0000_000A) begin
            errors++;
            $display("FAIL stream_drained got %h want 0000000a", csr_rdata);
        end
        bad = 0;
        repeat (30) begin
            if (uart_tx !== 1'b1 || csr_rdata[2] !== 1'b0) bad++;
            @(negedge clk);
        end
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL stream_dropped_sent bad_cycles=%0d want 0", bad);
        end
    endtask

    task automatic test_overflow_clear();
        int bad;
        write_word(32'h8000_00AB);
        checks++;
        if (csr_rdata !== 32'h2 || fifo_empty !== 1'b1) begin
            errors++;
            $display("FAIL clear_status got %h empty=%b want 00000002 empty=1", csr_rdata, fifo_empty);
        end
        bad = 0;
        repeat (20) begin
            if (uart_tx !== 1'b1 || csr_rdata[2] !== 1'b0) bad++;
            @(negedge clk);
        end
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL clear_no_frame bad_cycles=%0d want 0", bad);
        end
    endtask

    task automatic test_full_pop_collision();
        int waited;
        csr_we = 1'b1;
        for (int d = 0; d < 5; d++) begin
            csr_wdata = 32'hA1 + 32'(d);
            @(negedge clk);
        end
        csr_we    = 1'b0;
        csr_wdata = '0;
        checks++;
        if (csr_rdata !== 32'h0000_0405) begin
            errors++;
            $display("FAIL collide_filled got %h want 00000405", csr_rdata);
        end
        waited = 0;
        while (csr_rdata[2] !== 1'b0 && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        checks++;
        if (waited >= 200) begin
            errors++;
            $display("FAIL collide_wait_idle busy still set after %0d cycles, want idle", waited);
        end else begin
            checks++;
            if (csr_rdata !== 32'h0000_0401) begin
                errors++;
                $display("FAIL collide_idle got %h want 00000401", csr_rdata);
            end
            write_word(32'h0000_005A);
            checks++;
            if (csr_rdata !== 32'h0000_030C || fifo_full !== 1'b0) begin
                errors++;
                $display("FAIL collide_result got %h full=%b want 0000030c full=0", csr_rdata, fifo_full);
            end
        end
    endtask

    task automatic test_reset_mid_frame();
        int bad;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        write_word(32'h0000_003C);
        write_word(32'h0000_00F7);
        write_word(32'h0000_00A5);
        // Now one cycle into the first frame; the second frame's data bit 3 is 58 cycles in.
        repeat (57) @(negedge clk);
        checks++;
        if (uart_tx !== 1'b0 || csr_rdata[2] !== 1'b1) begin
            errors++;
            $display("FAIL midframe_pos tx=%b busy=%b want tx=0 busy=1", uart_tx, csr_rdata[2]);
        end
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (uart_tx !== 1'b1 || csr_rdata !== 32'h2) begin
            errors++;
            $display("FAIL midframe_reset tx=%b status=%h want tx=1 status=00000002", uart_tx, csr_rdata);
        end
        rst = 1'b0;
        bad = 0;
        repeat (60) begin
            if (uart_tx !== 1'b1 || csr_rdata !== 32'h2) bad++;
            @(negedge clk);
        end
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL midframe_quiet bad_cycles=%0d want 0", bad);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1);
    end

    initial begin
        @(negedge clk);
        test_reset();
        test_single_frame();
        test_overflow_stream();
        test_overflow_clear();
        test_full_pop_collision();
        test_reset_mid_frame();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
